writeback_stage: RTL and testbench

Final pipeline stage, directly downstream of the execution stage. It registers the EX→WB results and commits each instruction once: a GPR write and/or a push into an output FIFO. The FIFO is drained through a valid/ready data-out port. The stage back-pressures the pipeline when the FIFO cannot accept data, and it forwards its pending GPR result to decode/execute.

---
 rtl/writeback_stage.sv | 104 ++++++++++
 tb/tb_writeback_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: registers EX results, commits GPR writes and output-FIFO pushes,
// back-pressures upstream when the FIFO cannot take a word, and forwards the pending result.
module writeback_stage #(
    parameter int DATA_W    = 16,
    parameter int GPR_AW    = 3,
    parameter int OUT_DEPTH = 4,
    parameter int CNT_W     = 16,
    localparam int PTR_W    = $clog2(OUT_DEPTH),
    localparam int LVL_W    = PTR_W + 1
) (
    input  logic              clk,
    input  logic              internal_reset,
    input  logic              ex_wr_en,
    input  logic              ex_dataoutv,
    input  logic [GPR_AW-1:0] ex_dst,
    input  logic [DATA_W-1:0] ex_data,
    output logic              stall,
    output logic              gpr_we,
    output logic [GPR_AW-1:0] gpr_waddr,
    output logic [DATA_W-1:0] gpr_wdata,
    output logic              fwd_valid,
    output logic [GPR_AW-1:0] fwd_dst,
    output logic [DATA_W-1:0] fwd_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic [LVL_W-1:0]  fifo_level
);

    logic              wb_wr_en_q, wb_wr_en_d;
    logic              wb_dataoutv_q, wb_dataoutv_d;
    logic [GPR_AW-1:0] wb_dst_q, wb_dst_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic [DATA_W-1:0] mem_q [OUT_DEPTH];
    logic [DATA_W-1:0] mem_d [OUT_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;

    logic pop, room, push;

    always_comb begin
        pop   = (level_q != '0) & out_ready;
        // A same-cycle pop frees a slot, so a full FIFO being drained never stalls.
        room  = (level_q < LVL_W'(OUT_DEPTH)) | pop;
        stall = wb_dataoutv_q & ~room;
        push  = wb_dataoutv_q & ~stall;

        wb_wr_en_d    = stall ? wb_wr_en_q    : ex_wr_en;
        wb_dataoutv_d = stall ? wb_dataoutv_q : ex_dataoutv;
        wb_dst_d      = stall ? wb_dst_q      : ex_dst;
        wb_data_d     = stall ? wb_data_q     : ex_data;

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = wb_data_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        level_d = level_q;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (!push && pop) level_d = level_q - 1'b1;

        out_count_d = out_count_q + CNT_W'(push);
    end

    always_ff @(posedge clk) begin
        if (internal_reset) begin
            wb_wr_en_q    <= 1'b0;
            wb_dataoutv_q <= 1'b0;
            wb_dst_q      <= '0;
            wb_data_q     <= '0;
            mem_q         <= '{default: '0};
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            level_q       <= '0;
            out_count_q   <= '0;
        end else begin
            wb_wr_en_q    <= wb_wr_en_d;
            wb_dataoutv_q <= wb_dataoutv_d;
            wb_dst_q      <= wb_dst_d;
            wb_data_q     <= wb_data_d;
            mem_q         <= mem_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            level_q       <= level_d;
            out_count_q   <= out_count_d;
        end
    end

    assign gpr_we     = wb_wr_en_q & ~stall & ~internal_reset;
    assign gpr_waddr  = wb_dst_q;
    assign gpr_wdata  = wb_data_q;
    assign fwd_valid  = wb_wr_en_q;
    assign fwd_dst    = wb_dst_q;
    assign fwd_data   = wb_data_q;
    assign out_valid  = (level_q != '0);
    assign out_data   = mem_q[rd_ptr_q];
    assign out_count  = out_count_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed stimulus queues expected GPR writes and
// output words; a negedge monitor pops and compares whenever the DUT commits them.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        internal_reset;
    logic        ex_wr_en, ex_dataoutv;
    logic [2:0]  ex_dst;
    logic [15:0] ex_data;
    logic        stall, gpr_we, fwd_valid, out_valid, out_ready;
    logic [2:0]  gpr_waddr, fwd_dst;
    logic [15:0] gpr_wdata, fwd_data, out_data, out_count;
    logic [2:0]  fifo_level;

    int errors = 0;
    int checks = 0;

    logic [15:0] out_q[$];
    logic [18:0] gpr_q[$];

    writeback_stage #(.DATA_W(16), .GPR_AW(3), .OUT_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .internal_reset(internal_reset),
        .ex_wr_en(ex_wr_en), .ex_dataoutv(ex_dataoutv), .ex_dst(ex_dst), .ex_data(ex_data),
        .stall(stall), .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .out_count(out_count), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic dv, input logic [2:0] dst, input logic [15:0] d);
        ex_wr_en = wr; ex_dataoutv = dv; ex_dst = dst; ex_data = d;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && fifo_level != 0; i++) tick();
        check("drain_level", 32'(fifo_level), 0);
    endtask

    // Monitor: every committed GPR write / popped word must match the next expected one.
    always @(negedge clk) begin
        if (gpr_we) begin
            if (gpr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL gpr_unexpected: got %0h:%0h expected none", gpr_waddr, gpr_wdata);
            end else check("gpr_write", {13'd0, gpr_waddr, gpr_wdata}, {13'd0, gpr_q.pop_front()});
        end
        if (out_valid && out_ready) begin
            if (out_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL out_unexpected: got %0h expected none", out_data);
            end else check("out_data", 32'(out_data), 32'(out_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        internal_reset = 1'b1; out_ready = 1'b0;
        drive(0, 0, 0, 0);
        tick(); tick();
        internal_reset = 1'b0;
        check("rst_stall", 32'(stall), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_count", 32'(out_count), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_fwd_valid", 32'(fwd_valid), 0);

        // Single GPR write
        drive(1, 0, 3, 16'h1234); gpr_q.push_back({3'd3, 16'h1234});
        tick();
        drive(0, 0, 0, 0);
        check("t1_gpr_we", 32'(gpr_we), 1);
        check("t1_fwd_valid", 32'(fwd_valid), 1);
        check("t1_fwd_dst", 32'(fwd_dst), 3);
        check("t1_fwd_data", 32'(fwd_data), 32'h1234);
        tick();
        check("t1_gpr_we_off", 32'(gpr_we), 0);
        check("t1_out_valid", 32'(out_valid), 0);

        // Fill to full, fifth word stalls
        for (int i = 1; i <= 4; i++) begin
            drive(0, 1, 0, 16'hA000 + 16'(i)); out_q.push_back(16'hA000 + 16'(i));
            tick();
            check("t2_no_stall", 32'(stall), 0);
        end
        drive(0, 1, 0, 16'hA005); out_q.push_back(16'hA005);
        tick();
        drive(0, 0, 0, 0);
        check("t2_level_full", 32'(fifo_level), 4);
        check("t2_stall", 32'(stall), 1);
        tick();
        check("t2_stall_hold", 32'(stall), 1);
        check("t2_wb_hold", 32'(fwd_data), 32'hA005);
        check("t2_out_head", 32'(out_data), 32'hA001);
        out_ready = 1'b1;
        #1;
        check("t2_release", 32'(stall), 0);
        tick();
        check("t2_level_after", 32'(fifo_level), 4);
        drain();
        check("t2_count", 32'(out_count), 5);
        out_ready = 1'b0;

        // Both strobes while full
        for (int i = 1; i <= 4; i++) begin
            drive(0, 1, 0, 16'hB000 + 16'(i)); out_q.push_back(16'hB000 + 16'(i));
            tick();
        end
        drive(1, 1, 5, 16'h00FF); out_q.push_back(16'h00FF); gpr_q.push_back({3'd5, 16'h00FF});
        tick();
        drive(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            check("t3_stall", 32'(stall), 1);
            check("t3_no_gpr_we", 32'(gpr_we), 0);
            check("t3_fwd_valid", 32'(fwd_valid), 1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("t3_release_we", 32'(gpr_we), 1);
        drain();
        check("t3_count", 32'(out_count), 10);

        // Streaming with continuous ready: pointers wrap
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 0, 16'hC000 + 16'(i)); out_q.push_back(16'hC000 + 16'(i));
            tick();
            check("t4_no_stall", 32'(stall), 0);
        end
        drive(0, 0, 0, 0);
        drain();
        check("t4_count", 32'(out_count), 20);

        // Reset with full FIFO and a stalled entry
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(0, 1, 0, 16'hD000 + 16'(i));
            tick();
        end
        drive(1, 1, 6, 16'hEEEE);
        tick();
        drive(0, 0, 0, 0);
        check("t5_stall", 32'(stall), 1);
        check("t5_level", 32'(fifo_level), 4);
        internal_reset = 1'b1;
        tick();
        internal_reset = 1'b0;
        check("t5_out_valid", 32'(out_valid), 0);
        check("t5_level0", 32'(fifo_level), 0);
        check("t5_count0", 32'(out_count), 0);
        check("t5_stall0", 32'(stall), 0);
        check("t5_gpr_we", 32'(gpr_we), 0);
        check("t5_fwd_valid", 32'(fwd_valid), 0);
        tick(); tick();

        // Bubble
        out_ready = 1'b1;
        drive(0, 0, 7, 16'hFFFF);
        tick();
        drive(0, 0, 0, 0);
        check("t6_fwd_valid", 32'(fwd_valid), 0);
        check("t6_gpr_we", 32'(gpr_we), 0);
        check("t6_stall", 32'(stall), 0);
        tick();
        check("t6_out_valid", 32'(out_valid), 0);
        check("t6_count", 32'(out_count), 0);
        tick();

        check("sb_out_empty", 32'(out_q.size()), 0);
        check("sb_gpr_empty", 32'(gpr_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
